// File: rtl/outport_vc_allocator_pkg.sv
// rtl/outport_vc_allocator_pkg.sv - shared router constants for the outport VC allocator
package outport_vc_allocator_pkg;

  // Per-output-VC allocation state
  localparam logic VC_FREE  = 1'b0;
  localparam logic VC_ALLOC = 1'b1;

  // A credit counter of width w must be able to hold the value buf_size
  function automatic bit credit_width_ok(input int buf_size, input int w);
    return (buf_size < (1 << w));
  endfunction

endpackage

// File: rtl/outport_vc_allocator_picker.sv
// rtl/outport_vc_allocator_picker.sv - rotating-priority first-one picker
// Ports:
//   req     : request vector
//   ptr     : index that has highest priority this cycle
//   onehot  : one-hot winner (0 when no request)
//   idx     : winner index (0 when no request)
//   any     : at least one request present
module rr_priority_picker #(
  parameter int no_vc                   = 13,
  parameter int floorplusone_log2_no_vc = 4
) (
  input  logic [no_vc-1:0]                   req,
  input  logic [floorplusone_log2_no_vc-1:0] ptr,
  output logic [no_vc-1:0]                   onehot,
  output logic [floorplusone_log2_no_vc-1:0] idx,
  output logic                               any
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan ptr, ptr+1, ... wrapping at no_vc; first hit wins
    for (int k = 0; k < no_vc; k++) begin
      j = (int'(ptr) + k) % no_vc;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = floorplusone_log2_no_vc'(j);
      end
    end
  end

endmodule

// File: rtl/outport_vc_allocator.sv
// rtl/outport_vc_allocator.sv - per-outport wormhole output-VC allocator with credit tracking
// Ports:
//   clk, rs                  : clock, asynchronous active-low reset
//   req_vec / req_allowed    : input-VC requests and per-input allowed output-VC masks
//   tail_vec                 : per-input tail flit strobe, releases the held output VC
//   flit_sent / flit_vc      : consume one credit of an output VC
//   credit_in / credit_vc    : return one credit of an output VC
//   grant_valid/vec/outvc    : registered one-cycle grant (zeroed when idle)
//   outvc_busy, credit_avail : per-output-VC allocated flag and credit-nonzero flag
module outport_vc_allocator
  import outport_vc_allocator_pkg::*;
#(
  parameter int no_vc                      = 13,
  parameter int floorplusone_log2_no_vc    = 4,
  parameter int buf_size                   = 4,
  parameter int floorplusone_log2_buf_size = 4
) (
  input  logic                               clk,
  input  logic                               rs,
  input  logic [no_vc-1:0]                   req_vec,
  input  logic [no_vc*no_vc-1:0]             req_allowed,
  input  logic [no_vc-1:0]                   tail_vec,
  input  logic                               flit_sent,
  input  logic [floorplusone_log2_no_vc-1:0] flit_vc,
  input  logic                               credit_in,
  input  logic [floorplusone_log2_no_vc-1:0] credit_vc,
  output logic                               grant_valid,
  output logic [no_vc-1:0]                   grant_vec,
  output logic [floorplusone_log2_no_vc-1:0] grant_outvc,
  output logic [no_vc-1:0]                   outvc_busy,
  output logic [no_vc-1:0]                   credit_avail
);

  localparam int W  = floorplusone_log2_no_vc;
  localparam int CW = floorplusone_log2_buf_size;

  logic [CW-1:0]    credits [no_vc];
  logic [no_vc-1:0] held_valid;
  logic [W-1:0]     held_vc [no_vc];
  logic [W-1:0]     rr_ptr;

  logic [no_vc-1:0] grantable;
  logic [no_vc-1:0] cand_vec;
  logic [no_vc-1:0] pick_onehot;
  logic [W-1:0]     pick_idx;
  logic             pick_any;
  logic [no_vc-1:0] win_mask;
  logic [W-1:0]     win_vc;
  logic             win_found;
  logic             credit_ovf;
  logic             credit_udf;

  always_comb begin
    credit_avail = '0;
    for (int v = 0; v < no_vc; v++) credit_avail[v] = (credits[v] != '0);
  end

  // All terms come from pre-edge state, so a VC released this cycle is not grantable yet
  assign grantable = ~outvc_busy & credit_avail;

  always_comb begin
    cand_vec = '0;
    for (int i = 0; i < no_vc; i++)
      cand_vec[i] = req_vec[i] & ~held_valid[i] & (|(req_allowed[i*no_vc +: no_vc] & grantable));
  end

  rr_priority_picker #(
    .no_vc                   (no_vc),
    .floorplusone_log2_no_vc (W)
  ) u_picker (
    .req    (cand_vec),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Lowest grantable output VC in the winning input's allowed mask
  always_comb begin
    win_mask  = '0;
    for (int i = 0; i < no_vc; i++)
      if (pick_onehot[i]) win_mask = req_allowed[i*no_vc +: no_vc] & grantable;
    win_vc    = '0;
    win_found = 1'b0;
    for (int v = 0; v < no_vc; v++) begin
      if (!win_found && win_mask[v]) begin
        win_found = 1'b1;
        win_vc    = W'(v);
      end
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      grant_valid <= 1'b0;
      grant_vec   <= '0;
      grant_outvc <= '0;
      outvc_busy  <= {no_vc{VC_FREE}};
      held_valid  <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < no_vc; i++) held_vc[i] <= '0;
    end else begin
      // Release on tail; a tail from an input holding nothing is ignored
      for (int i = 0; i < no_vc; i++) begin
        if (tail_vec[i] && held_valid[i]) begin
          held_valid[i]          <= 1'b0;
          outvc_busy[held_vc[i]] <= VC_FREE;
        end
      end
      // A releasing input is held, hence never the winner; the two writes never collide
      if (pick_any) begin
        grant_valid          <= 1'b1;
        grant_vec            <= pick_onehot;
        grant_outvc          <= win_vc;
        outvc_busy[win_vc]   <= VC_ALLOC;
        held_valid[pick_idx] <= 1'b1;
        held_vc[pick_idx]    <= win_vc;
        rr_ptr               <= (pick_idx == W'(no_vc - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        grant_valid <= 1'b0;
        grant_vec   <= '0;
        grant_outvc <= '0;
      end
    end
  end

  // Out-of-range VC numbers never match any v, so they drop out naturally
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      for (int v = 0; v < no_vc; v++) credits[v] <= CW'(buf_size);
    end else begin
      for (int v = 0; v < no_vc; v++) begin
        if (credit_in && credit_vc == W'(v) && !(flit_sent && flit_vc == W'(v))) begin
          if (credits[v] != CW'(buf_size)) credits[v] <= credits[v] + 1'b1;
        end else if (flit_sent && flit_vc == W'(v) && !(credit_in && credit_vc == W'(v))) begin
          if (credits[v] != '0) credits[v] <= credits[v] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    credit_ovf = 1'b0;
    credit_udf = 1'b0;
    for (int v = 0; v < no_vc; v++) begin
      if (credit_in && credit_vc == W'(v) && !(flit_sent && flit_vc == W'(v)) &&
          credits[v] == CW'(buf_size))
        credit_ovf = 1'b1;
      if (flit_sent && flit_vc == W'(v) && !(credit_in && credit_vc == W'(v)) &&
          credits[v] == '0)
        credit_udf = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rs) begin
      assert (!credit_ovf) else $warning("credit returned to a VC already at buf_size");
      assert (!credit_udf) else $warning("flit sent on a VC with zero credit");
    end
  end

endmodule
